// File: rtl/memory_stream_reader.sv
// memory_stream_reader
//   Read-side sequencer for a single-write-port RAM with a combinational read port.
//   A start command walks the RAM from base_addr for count words and emits them
//   as a valid/ready stream. Addresses wrap circularly at LENGTH.
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               command strobe, sampled only while idle
//   base_addr, count    command arguments, sampled with start (count may be 0)
//   busy                high from accepted start until the command finishes
//   done, err           one-cycle pulses: command finished / command rejected
//   r_addr, r_data      RAM read port (data is combinational from address)
//   m_valid, m_ready    stream handshake
//   m_data, m_last      registered stream word and end-of-command marker
module memory_stream_reader #(
    parameter int WIDTH     = 32,
    parameter int LENGTH    = 10,
    parameter int ADDR_SIZE = $clog2(LENGTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE:0]   count,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_SIZE-1:0] r_addr,
    input  logic [WIDTH-1:0]     r_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    localparam logic [ADDR_SIZE:0]   LEN_V   = (ADDR_SIZE+1)'(LENGTH);
    localparam logic [ADDR_SIZE-1:0] LAST_A  = ADDR_SIZE'(LENGTH - 1);
    localparam logic [ADDR_SIZE:0]   ONE_CNT = (ADDR_SIZE+1)'(1);

    state_t               state, state_n;
    logic [ADDR_SIZE-1:0] addr;
    logic [ADDR_SIZE:0]   remaining;
    logic                 accept, capture, finish, reject, empty_cmd;
    logic [ADDR_SIZE-1:0] addr_inc;

    // The read address is the walk pointer itself: in STREAM it already points
    // at the next word, so a handshake can capture it without a bubble.
    assign r_addr   = addr;
    assign busy     = (state != IDLE);
    assign addr_inc = (addr == LAST_A) ? '0 : addr + 1'b1;

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        reject    = 1'b0;
        empty_cmd = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if ({1'b0, base_addr} >= LEN_V) begin
                        reject = 1'b1;
                    end else if (count == '0) begin
                        empty_cmd = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                capture = 1'b1;
                state_n = STREAM;
            end
            STREAM: begin
                if (m_valid && m_ready) begin
                    if (m_last) begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            done  <= finish | empty_cmd;
            err   <= reject;
            if (accept) begin
                addr      <= base_addr;
                remaining <= count;
            end
            if (capture) begin
                m_data    <= r_data;
                m_valid   <= 1'b1;
                m_last    <= (remaining == ONE_CNT);
                addr      <= addr_inc;
                remaining <= remaining - 1'b1;
            end
            if (finish) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Bench for memory_stream_reader: a queue-based model predicts each stream word,
// handshake timing and status pulses; directed commands with literal expected
// word lists pin the model.
module tb_memory_stream_reader;
    localparam int W = 32;
    localparam int L = 10;
    localparam int A = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [A-1:0] base_addr;
    logic [A:0]   count;
    logic         m_ready;
    logic         busy, done, err, m_valid, m_last;
    logic [A-1:0] r_addr;
    logic [W-1:0] r_data, m_data;
    logic [W-1:0] mem [L];

    memory_stream_reader #(.WIDTH(W), .LENGTH(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .busy(busy), .done(done), .err(err), .r_addr(r_addr),
        .r_data(r_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last)
    );

    assign r_data = (int'(r_addr) < L) ? mem[r_addr] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // model state: expectations for the current negedge
    logic [W-1:0] q[$];
    logic [W-1:0] seen[$];
    int lat = 0;
    bit e_busy = 0, e_done = 0, e_err = 0, e_valid = 0;
    int done_cnt = 0, err_cnt = 0;

    always @(negedge clk) begin
        bit n_busy, n_done, n_err;
        if (rst_n !== 1'b1) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_last", m_last, 0);
            chk("rst_data", m_data, 0);
            q.delete();
            lat = 0;
            e_busy = 0; e_done = 0; e_err = 0; e_valid = 0;
        end else begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("m_valid", m_valid, e_valid);
            if (e_valid) begin
                chk("m_data", m_data, q[0]);
                chk("m_last", m_last, (q.size() == 1) ? 1 : 0);
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            n_busy = e_busy; n_done = 0; n_err = 0;
            if (e_valid && m_ready) begin
                seen.push_back(q.pop_front());
                if (q.size() == 0) begin
                    n_busy = 0;
                    n_done = 1;
                end
            end
            if (lat > 0) lat--;
            e_valid = (lat == 0 && q.size() > 0);
            if (start && !e_busy) begin
                if (int'(base_addr) >= L) n_err = 1;
                else if (count == 0) n_done = 1;
                else begin
                    for (int i = 0; i < int'(count); i++)
                        q.push_back(mem[(int'(base_addr) + i) % L]);
                    lat = 1;
                    n_busy = 1;
                end
            end
            e_busy = n_busy; e_done = n_done; e_err = n_err;
        end
    end

    task automatic cmd(input int b, input int c);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = A'(b);
        count = (A+1)'(c);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int t = 0;
        while (!(done || err) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL %s_timeout: got no done/err expected pulse within 100 cycles", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_seen(input string name, input logic [W-1:0] exp[$]);
        chk({name, "_len"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            chk({name, "_word"}, seen[i], exp[i]);
        seen.delete();
    endtask

    initial begin
        logic [W-1:0] ex[$];
        logic [5:0] pat;
        int d0;
        for (int i = 0; i < L; i++) mem[i] = 100 + i;
        start = 0; base_addr = '0; count = '0; m_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_r_addr", r_addr, 0);

        // basic command, with first-word latency pinned
        cmd(2, 4);
        @(negedge clk); chk("lat_cycle1_valid", m_valid, 0);
        @(negedge clk); chk("lat_cycle2_valid", m_valid, 1);
        wait_end("t1");
        ex = {102, 103, 104, 105}; check_seen("t1", ex);

        // wrap at LENGTH-1
        cmd(8, 5);
        wait_end("t2");
        ex = {108, 109, 100, 101, 102}; check_seen("t2", ex);

        // count > LENGTH, plus a start mid-stream that must be ignored
        cmd(0, 12);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; base_addr = 4'd5; count = 5'd2;
        @(posedge clk); #1 start = 1'b0;
        wait_end("t3");
        ex = {100, 101, 102, 103, 104, 105, 106, 107, 108, 109, 100, 101};
        check_seen("t3", ex);
        repeat (4) @(posedge clk);
        chk("t3_no_extra", seen.size(), 0);

        // backpressure
        pat = 6'b101001;
        cmd(3, 3);
        for (int i = 0; i < 6; i++) begin
            m_ready = pat[i];
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_end("t4");
        ex = {103, 104, 105}; check_seen("t4", ex);

        // zero count and rejected base
        d0 = done_cnt;
        cmd(4, 0);
        wait_end("t5");
        chk("t5_done_pulses", done_cnt - d0, 1);
        chk("t5_no_words", seen.size(), 0);
        d0 = err_cnt;
        cmd(10, 3);
        wait_end("t6");
        chk("t6_err_pulses", err_cnt - d0, 1);
        chk("t6_no_words", seen.size(), 0);

        // reset on the second beat
        d0 = done_cnt;
        cmd(0, 5);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t7_valid_drop", m_valid, 0);
        chk("t7_busy_drop", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("t7_no_done", done_cnt - d0, 0);
        ex = {100}; check_seen("t7", ex);

        // recovery after reset
        cmd(2, 4);
        wait_end("t8");
        ex = {102, 103, 104, 105}; check_seen("t8", ex);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
